// File: rtl/quadrant_stepper_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quadrant_stepper_driver_pkg                                     |
// | Purpose  : Shared definitions for the quadrant stepper driver and the      |
// |            quadrant angle FSM: quadrant codes, driver FSM state encoding,  |
// |            full-step coil phase patterns and the phase decoder.            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package quadrant_stepper_driver_pkg;

   // Quadrant codes, shared with the angle FSM
   localparam logic [1:0] POS_0   = 2'b00;
   localparam logic [1:0] POS_90  = 2'b01;
   localparam logic [1:0] POS_180 = 2'b10;
   localparam logic [1:0] POS_270 = 2'b11;

   // Driver FSM state encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP_HI = 2'd1,
      STEP_LO = 2'd2
   } state_t;

   // Two-phase-on full-step patterns, listed in CW order
   localparam logic [3:0] COIL_PH0 = 4'b0011;
   localparam logic [3:0] COIL_PH1 = 4'b0110;
   localparam logic [3:0] COIL_PH2 = 4'b1100;
   localparam logic [3:0] COIL_PH3 = 4'b1001;

   function automatic logic [3:0] phase_to_coils(input logic [1:0] phase);
      logic [3:0] coils;
      coils = COIL_PH0;
      case (phase)
         2'd0: coils = COIL_PH0;
         2'd1: coils = COIL_PH1;
         2'd2: coils = COIL_PH2;
         2'd3: coils = COIL_PH3;
         default: coils = COIL_PH0;
      endcase
      return coils;
   endfunction

endpackage
`default_nettype wire

// File: rtl/quadrant_stepper_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quadrant_stepper_driver_if                                      |
// | Purpose  : Command/status bundle between the angle FSM (master) and the    |
// |            stepper driver (slave).                                         |
// | Signals  : enable, desired_position   master -> slave                      |
// |            physical_position, step, dir, busy, coils   slave -> master     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface quadrant_stepper_driver_if;
   logic       enable;
   logic [1:0] desired_position;
   logic [1:0] physical_position;
   logic       step;
   logic       dir;
   logic       busy;
   logic [3:0] coils;

   modport master (
      output enable, desired_position,
      input  physical_position, step, dir, busy, coils
   );

   modport slave (
      input  enable, desired_position,
      output physical_position, step, dir, busy, coils
   );
endinterface
`default_nettype wire

// File: rtl/quadrant_stepper_driver_coil_phase_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coil_phase_seq                                                  |
// | Purpose  : 2-bit full-step phase index, advanced one phase per request in  |
// |            the requested direction and decoded to a registered coil drive. |
// | Ports    : clk, rst     clock, synchronous active-high reset               |
// |            i_advance    step the phase by one this cycle                   |
// |            i_dir        1 = CW (next phase), 0 = CCW (previous phase)      |
// |            o_coils      registered coil pattern, 4'b0011 after reset       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module coil_phase_seq
   import quadrant_stepper_driver_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       i_advance,
   input  wire logic       i_dir,
   output logic [3:0]      o_coils
);

   logic [1:0] r_phase;
   logic [3:0] r_coils;
   logic [1:0] w_phase_next;

   always_comb begin
      w_phase_next = r_phase;
      if (i_advance) begin
         w_phase_next = i_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
      end
   end

   // Coils are decoded from the next phase so the pattern is a flop output
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= 2'd0;
         r_coils <= COIL_PH0;
      end else begin
         r_phase <= w_phase_next;
         r_coils <= phase_to_coils(w_phase_next);
      end
   end

   assign o_coils = r_coils;

endmodule
`default_nettype wire

// File: rtl/quadrant_stepper_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quadrant_stepper_driver                                         |
// | Purpose  : Moves a 4-phase full-step motor one quadrant at a time along    |
// |            the shortest path towards the commanded quadrant and reports    |
// |            the last fully reached quadrant.                                |
// | Ports    : clk, rst   clock, synchronous active-high reset                 |
// |            bus        slave side of quadrant_stepper_driver_if:            |
// |                       enable, desired_position in;                         |
// |                       physical_position, step, dir, busy, coils out        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module quadrant_stepper_driver
   import quadrant_stepper_driver_pkg::*;
#(
   parameter int         STEPS_PER_QUADRANT = 50,
   parameter int         STEP_PERIOD        = 20000,
   parameter int         STEP_HIGH          = 10000,
   parameter logic [1:0] HOME_POSITION      = POS_0
)(
   input  wire logic                    clk,
   input  wire logic                    rst,
   quadrant_stepper_driver_if.slave     bus
);

   localparam int TW = $clog2(STEP_PERIOD);
   localparam int CW = (STEPS_PER_QUADRANT > 1) ? $clog2(STEPS_PER_QUADRANT) : 1;

   localparam logic [TW-1:0] C_HI_LAST  = TW'(STEP_HIGH - 1);
   localparam logic [TW-1:0] C_PER_LAST = TW'(STEP_PERIOD - 1);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(STEPS_PER_QUADRANT - 1);

   state_t          r_state;
   logic [TW-1:0]   r_timer;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_pos;
   logic            r_step;
   logic            r_dir;
   logic            r_busy;

   logic [1:0]      w_delta;
   logic            w_start;
   logic            w_new_dir;
   logic            w_step_end;
   logic            w_quad_end;
   logic            w_advance;
   logic            w_phase_dir;
   logic [3:0]      w_coils;

   assign w_delta    = bus.desired_position - r_pos;
   assign w_start    = (r_state == IDLE) && bus.enable && (w_delta != 2'd0);
   // d=1 and the d=2 tie both go CW; only d=3 goes CCW
   assign w_new_dir  = (w_delta != 2'd3);
   // Timer runs across the whole step, so its last value closes STEP_LO
   assign w_step_end = (r_state == STEP_LO) && (r_timer == C_PER_LAST);
   assign w_quad_end = w_step_end && (r_cnt == C_CNT_LAST);
   assign w_advance  = w_start || (w_step_end && !w_quad_end);
   // On the IDLE->STEP_HI edge r_dir is not yet updated, so use the new one
   assign w_phase_dir = (r_state == IDLE) ? w_new_dir : r_dir;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_cnt   <= '0;
         r_pos   <= HOME_POSITION;
         r_step  <= 1'b0;
         r_dir   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state <= STEP_HI;
                  r_dir   <= w_new_dir;
                  r_step  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_timer <= '0;
               end
            end
            STEP_HI: begin
               r_timer <= r_timer + TW'(1);
               if (r_timer == C_HI_LAST) begin
                  r_state <= STEP_LO;
                  r_step  <= 1'b0;
               end
            end
            STEP_LO: begin
               if (w_step_end) begin
                  r_timer <= '0;
                  if (w_quad_end) begin
                     r_cnt   <= '0;
                     r_pos   <= r_dir ? (r_pos + 2'd1) : (r_pos - 2'd1);
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt   <= r_cnt + CW'(1);
                     r_state <= STEP_HI;
                     r_step  <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_step  <= 1'b0;
               r_busy  <= 1'b0;
               r_timer <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   coil_phase_seq u_coil_phase_seq (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_advance),
      .i_dir     (w_phase_dir),
      .o_coils   (w_coils)
   );

   assign bus.physical_position = r_pos;
   assign bus.step              = r_step;
   assign bus.dir               = r_dir;
   assign bus.busy              = r_busy;
   assign bus.coils             = w_coils;

endmodule
`default_nettype wire

// File: tb/tb_quadrant_stepper_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_quadrant_stepper_driver                                      |
// | Purpose  : Self-checking bench for quadrant_stepper_driver with            |
// |            STEPS_PER_QUADRANT=4, STEP_PERIOD=4, STEP_HIGH=2, HOME=00.      |
// |            Expected outputs are queued when stimulus is applied and        |
// |            compared on the falling edge of the following cycle.            |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_quadrant_stepper_driver;

   typedef struct packed {
      logic       step;
      logic       dir;
      logic       busy;
      logic [3:0] coils;
      logic [1:0] pos;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] des;
      exp_t       exp;
   } vec_t;

   logic clk;
   logic rst;

   quadrant_stepper_driver_if bus ();

   quadrant_stepper_driver #(
      .STEPS_PER_QUADRANT (4),
      .STEP_PERIOD        (4),
      .STEP_HIGH          (2),
      .HOME_POSITION      (2'b00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_errors = 0;
   exp_t  sb_exp[$];
   string sb_name[$];

   logic [3:0] cw_seq [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

   localparam exp_t EXP_RST  = '{step:1'b0, dir:1'b0, busy:1'b0, coils:4'b0011, pos:2'b00};

   // Monitor: outputs settle after the rising edge, compare mid-cycle
   always @(negedge clk) begin
      if (sb_exp.size() != 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = sb_exp.pop_front();
         nm = sb_name.pop_front();
         a  = {bus.step, bus.dir, bus.busy, bus.coils, bus.physical_position};
         n_checks++;
         if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got step=%0b dir=%0b busy=%0b coils=%04b pos=%02b, want step=%0b dir=%0b busy=%0b coils=%04b pos=%02b",
                     nm, a.step, a.dir, a.busy, a.coils, a.pos,
                     e.step, e.dir, e.busy, e.coils, e.pos);
         end
      end
   end

   // Current inputs are sampled by the next rising edge; queue what must follow
   task automatic apply(input exp_t e, input string nm);
      @(posedge clk);
      #1;
      sb_exp.push_back(e);
      sb_name.push_back(nm);
   endtask

   function automatic exp_t mk_exp(input logic s, input logic d, input logic b,
                                   input logic [3:0] c, input logic [1:0] p);
      exp_t e;
      e.step = s; e.dir = d; e.busy = b; e.coils = c; e.pos = p;
      return e;
   endfunction

   function automatic vec_t mk_vec(input logic r, input logic en, input logic [1:0] des, input exp_t e);
      vec_t v;
      v.rst = r; v.en = en; v.des = des; v.exp = e;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.enable = 1'b1;
      bus.desired_position = 2'b00;
      apply(EXP_RST, "reset");
      rst = 1'b0;
   endtask

   // Cycles 1..klast of one quadrant starting from p0 with coil phase ph0.
   // Each step is 1,1,0,0 on step; coils advance on the first cycle of each step.
   task automatic run_quadrant(input string nm, input logic [1:0] p0, input logic d,
                               input int ph0, input int klast,
                               input int sw_k, input logic [1:0] sw_val);
      exp_t e;
      int   idx;
      for (int k = 1; k <= klast; k++) begin
         if (k <= 16) begin
            idx    = d ? (ph0 + (k - 1) / 4 + 1) : (ph0 - (k - 1) / 4 - 1);
            e.step = (((k - 1) % 4) < 2);
            e.busy = 1'b1;
            e.pos  = p0;
         end else begin
            idx    = d ? (ph0 + 4) : (ph0 - 4);
            e.step = 1'b0;
            e.busy = 1'b0;
            e.pos  = d ? (p0 + 2'd1) : (p0 - 2'd1);
         end
         e.dir   = d;
         e.coils = cw_seq[((idx % 4) + 4) % 4];
         apply(e, $sformatf("%s_c%0d", nm, k));
         if (k == sw_k) bus.desired_position = sw_val;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vt[34];
      exp_t idle00;

      idle00 = mk_exp(1'b0, 1'b0, 1'b0, 4'b0011, 2'b00);
      // Reset, then d=0 with enable high for 20 cycles
      vt[0] = mk_vec(1'b1, 1'b1, 2'b00, EXP_RST);
      for (int i = 1; i <= 20; i++) vt[i] = mk_vec(1'b0, 1'b1, 2'b00, idle00);
      // enable low with a pending move for 10 cycles
      for (int i = 21; i <= 30; i++) vt[i] = mk_vec(1'b0, 1'b0, 2'b01, idle00);
      // raising enable starts the move on the very next cycle
      vt[31] = mk_vec(1'b0, 1'b1, 2'b01, mk_exp(1'b1, 1'b1, 1'b1, 4'b0110, 2'b00));
      // reset right after the move starts
      vt[32] = mk_vec(1'b1, 1'b1, 2'b00, EXP_RST);
      vt[33] = mk_vec(1'b0, 1'b1, 2'b00, idle00);

      rst = 1'b1;
      bus.enable = 1'b0;
      bus.desired_position = 2'b00;

      for (int i = 0; i < 34; i++) begin
         rst                  = vt[i].rst;
         bus.enable           = vt[i].en;
         bus.desired_position = vt[i].des;
         apply(vt[i].exp, $sformatf("tbl%0d", i));
      end

      // 00 -> 01, CW
      bus.desired_position = 2'b01;
      run_quadrant("cw01", 2'b00, 1'b1, 0, 17, 0, 2'b00);

      // 00 -> 11, CCW
      do_reset();
      bus.desired_position = 2'b11;
      run_quadrant("ccw11", 2'b00, 1'b0, 0, 17, 0, 2'b00);

      // 00 -> 10: tie goes CW, two chained quadrants with one IDLE cycle
      do_reset();
      bus.desired_position = 2'b10;
      run_quadrant("half_a", 2'b00, 1'b1, 0, 17, 0, 2'b00);
      run_quadrant("half_b", 2'b01, 1'b1, 0, 17, 0, 2'b00);

      // Command changes to 11 mid-quadrant; from 01 d=2 keeps going CW
      do_reset();
      bus.desired_position = 2'b01;
      run_quadrant("sw_a", 2'b00, 1'b1, 0, 17, 5, 2'b11);
      run_quadrant("sw_b", 2'b01, 1'b1, 0, 17, 0, 2'b00);
      run_quadrant("sw_c", 2'b10, 1'b1, 0, 17, 0, 2'b00);

      // Reset during cycle 9 of a move
      do_reset();
      bus.desired_position = 2'b01;
      run_quadrant("rmid", 2'b00, 1'b1, 0, 9, 0, 2'b00);
      rst = 1'b1;
      bus.desired_position = 2'b00;
      apply(EXP_RST, "rmid_reset");
      rst = 1'b0;
      apply(idle00, "rmid_idle");

      repeat (3) @(negedge clk);
      #1;
      if (sb_exp.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending, want 0", sb_exp.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
